// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready handshake bundle carrying a PC and a payload word
interface pipe_stage_reg_if #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    modport master (output valid, pc, data, input ready);
    modport slave  (input valid, pc, data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: registered pipeline stage with flush, stall counter and optional skid entry (PIPE_STAGE_SKID_EN)
module pipe_stage_reg #(
    parameter int                PC_W        = 32,
    parameter int                DATA_W      = 32,
    parameter int                CNT_W       = 16,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    pipe_stage_reg_if.slave         in_if,
    pipe_stage_reg_if.master        out_if,
    output logic [CNT_W-1:0]        stall_cnt_o
);
    logic              main_valid_q, main_valid_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              in_xfer, out_xfer;

    assign out_xfer = main_valid_q && out_if.ready;
    assign in_xfer  = in_if.valid && in_if.ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    // Readiness depends only on skid occupancy, breaking the out_ready timing path
    assign in_if.ready = reset && !flush_i && !skid_valid_q;

    // Main entry refills from skid first (order), then from input; otherwise input parks in skid
    always_comb begin
        main_valid_d = main_valid_q;
        main_pc_d    = main_pc_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            main_pc_d    = '0;
            main_data_d  = BUBBLE_DATA;
            skid_valid_d = 1'b0;
        end else if (out_xfer || !main_valid_q) begin
            main_valid_d = skid_valid_q || in_xfer;
            main_pc_d    = skid_valid_q ? skid_pc_q : (in_xfer ? in_if.pc : '0);
            main_data_d  = skid_valid_q ? skid_data_q : (in_xfer ? in_if.data : BUBBLE_DATA);
            skid_valid_d = 1'b0;
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = in_if.pc;
            skid_data_d  = in_if.data;
        end
    end

    // Skid entry register
    always_ff @(posedge clk) begin
        if (!reset) begin
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_data_q  <= BUBBLE_DATA;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    // Single entry: accept when empty or when the held entry leaves this cycle
    assign in_if.ready = reset && !flush_i && (out_if.ready || !main_valid_q);

    // Load on input transfer, drop to bubble when the entry leaves with nothing behind it
    always_comb begin
        main_valid_d = main_valid_q;
        main_pc_d    = main_pc_q;
        main_data_d  = main_data_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            main_pc_d    = '0;
            main_data_d  = BUBBLE_DATA;
        end else if (in_xfer) begin
            main_valid_d = 1'b1;
            main_pc_d    = in_if.pc;
            main_data_d  = in_if.data;
        end else if (out_xfer) begin
            main_valid_d = 1'b0;
            main_pc_d    = '0;
            main_data_d  = BUBBLE_DATA;
        end
    end
`endif

    // Back-pressure counter saturates at all-ones and ignores flush
    always_comb begin
        stall_cnt_d = (main_valid_q && !out_if.ready && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    // Output entry and counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            main_pc_q    <= '0;
            main_data_q  <= BUBBLE_DATA;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_pc_q    <= main_pc_d;
            main_data_q  <= main_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign out_if.valid = main_valid_q;
    assign out_if.pc    = main_pc_q;
    assign out_if.data  = main_data_q;
    assign stall_cnt_o  = stall_cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random stimulus checked against a queue-based reference of pipe_stage_reg
module tb_pipe_stage_reg;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [15:0] stall_cnt;
    int          checks = 0;
    int          fails = 0;
    logic [31:0] q_pc[$];
    logic [31:0] q_data[$];
    logic [15:0] m_stall = '0;

    pipe_stage_reg_if #(.PC_W(32), .DATA_W(32)) up ();
    pipe_stage_reg_if #(.PC_W(32), .DATA_W(32)) dn ();

    pipe_stage_reg dut (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .in_if       (up),
        .out_if      (dn),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare against the reference queue, then advance both across one clock edge
    task automatic step();
        logic exp_rdy;
        logic has;
        #1;
        has = q_pc.size() > 0;
        exp_rdy = reset && !flush && ((CAP == 2) ? (q_pc.size() < 2) : (!has || dn.ready));
        chk("in_ready", 64'(up.ready), 64'(exp_rdy));
        chk("out_valid", 64'(dn.valid), 64'(has));
        chk("out_pc", 64'(dn.pc), has ? 64'(q_pc[0]) : 64'd0);
        chk("out_data", 64'(dn.data), has ? 64'(q_data[0]) : 64'd0);
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        if (!reset) begin
            q_pc.delete();
            q_data.delete();
            m_stall = '0;
        end else begin
            if (has && !dn.ready && m_stall != 16'hFFFF) m_stall++;
            if (flush) begin
                q_pc.delete();
                q_data.delete();
            end else begin
                if (has && dn.ready) begin
                    void'(q_pc.pop_front());
                    void'(q_data.pop_front());
                end
                if (up.valid && exp_rdy) begin
                    q_pc.push_back(up.pc);
                    q_data.push_back(up.data);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic rst_n, input logic fl, input logic iv, input logic [31:0] pc,
                         input logic [31:0] data, input logic ordy);
        reset = rst_n;
        flush = fl;
        up.valid = iv;
        up.pc = pc;
        up.data = data;
        dn.ready = ordy;
    endtask

    initial begin
        drive(1'b0, 1'b1, 1'b1, 32'h5, 32'h6, 1'b0);
        @(posedge clk);
        @(negedge clk);
        step();
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b1);
            step();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h20, 32'hA0, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'h24, 32'hA4, 1'b0);
            step();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step();
        step();
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h30, 32'hB0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h34, 32'hB4, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b1, 32'h38, 32'hB8, 1'b1);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h40, 32'hC0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step();
        step();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                  $urandom, $urandom, $urandom_range(0, 3) != 0);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h50, 32'hD0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 65538; i++) step();
        drive(1'b0, 1'b1, 1'b1, 32'h60, 32'hE0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter PC_W, default 32, meaning PC field width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning payload (instruction/data) width in bits.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width in bits.
REQ-004 The block SHALL have parameter BUBBLE_DATA, default all-zero DATA_W, meaning the out_data value presented when the stage holds no valid entry.
REQ-005 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 The block SHALL have port flush  input  1  discards all held entries and inserts a bubble.
REQ-008 The block SHALL have port in_valid  input  1  upstream entry present.
REQ-009 The block SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-010 The block SHALL have ports in_pc  input  PC_W  and  in_data  input  DATA_W, the upstream payload.
REQ-011 The block SHALL have port out_valid  output  1  downstream entry present.
REQ-012 The block SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-013 The block SHALL have ports out_pc  output  PC_W  and  out_data  output  DATA_W, the registered payload.
REQ-014 The block SHALL have port stall_cnt  output  CNT_W  count of back-pressured cycles.

Function
REQ-015 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer on a rising edge with out_valid=1 and out_ready=1.
REQ-016 out_pc, out_data and out_valid SHALL be driven directly from registers (no combinational path from inputs).
REQ-017 While out_valid=0, out_pc SHALL be 0 and out_data SHALL be BUBBLE_DATA.
REQ-018 While out_valid=1 and out_ready=0, out_pc/out_data SHALL hold stable.
REQ-019 Latency SHALL be one cycle: an entry accepted into an empty stage appears on out_* with out_valid=1 on the next cycle.
REQ-020 Entries SHALL leave in acceptance order; none duplicated or dropped except by flush or reset.
REQ-021 An output transfer with no simultaneous input transfer (and no pending entry behind it) SHALL clear out_valid and load the bubble values.
REQ-022 Simultaneous input and output transfers SHALL replace the output entry with the next entry in order, out_valid remaining 1.
REQ-023 flush=1 SHALL force in_ready=0 and, on that edge, clear every held entry, set out_valid=0, out_pc=0, out_data=BUBBLE_DATA; out_ready is ignored that cycle.
REQ-024 stall_cnt SHALL increment by 1 on each edge with out_valid=1 and out_ready=0, saturate at all-ones, and be unaffected by flush.

Reset
REQ-025 On a rising edge with reset=0, out_valid=0, out_pc=0, out_data=BUBBLE_DATA, stall_cnt=0, and every internal entry SHALL be discarded, regardless of flush, in_valid or out_ready.
REQ-026 in_ready SHALL be 0 while reset=0; reset SHALL take priority over flush.
REQ-027 On the first edge after reset deasserts, the stage SHALL be empty with in_ready=1 (absent flush).

Configuration
REQ-028 Macro PIPE_STAGE_SKID_EN SHALL select the buffering mode.
REQ-029 Without PIPE_STAGE_SKID_EN: one entry; in_ready = !flush && (out_ready || !out_valid), combinational from out_ready.
REQ-030 With PIPE_STAGE_SKID_EN: a second skid entry; in_ready = !flush && !skid_valid, with no path from out_ready.
REQ-031 With PIPE_STAGE_SKID_EN: an input transfer while the main entry is valid and not leaving SHALL fill the skid entry.
REQ-032 With PIPE_STAGE_SKID_EN: an output transfer with skid full SHALL move the skid entry to out_*, empty the skid, and keep out_valid=1.
REQ-033 With PIPE_STAGE_SKID_EN: sustained in_valid=1 and out_ready=1 SHALL give one transfer per cycle, and at most two entries SHALL ever be held.

Verification
REQ-034 Reset, then in_valid=1, in_pc=0x100, in_data=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_pc=0x100, out_data=0xDEADBEEF; following cycle, with in_valid=0 -> out_valid=0, out_pc=0, out_data=BUBBLE_DATA.
REQ-035 Stream PCs 0x0,0x4,0x8,0xC with out_ready=1 -> out_pc sequence 0x0,0x4,0x8,0xC on consecutive cycles, stall_cnt=0.
REQ-036 Hold out_ready=0 for 5 cycles with entry 0x20 held -> out_pc stays 0x20, stall_cnt=5; in SKID_EN build, exactly one further entry 0x24 accepted, then in_ready=0; release -> 0x20 then 0x24.
REQ-037 Two entries held (SKID_EN), assert flush for one cycle with in_valid=1 -> in_ready=0, next cycle out_valid=0, out_data=BUBBLE_DATA, stall_cnt unchanged, stage then accepts new entry 0x40.
REQ-038 Preload stall_cnt to all-ones via 65535+ stalled cycles (CNT_W=16), stall 3 more -> stall_cnt stays 0xFFFF; assert reset=0 mid-stall with flush=1 -> next cycle all outputs at reset values, stall_cnt=0.
